// File: rtl/cache2instr_rsp.sv
// I$ -> core instruction response converter: credit-gated grants, DEPTH-entry in-order
// response FIFO with fall-through. Optional CACHE2INSTR_SPURIOUS_CHK_EN flags unrequested responses.
module cache2instr_rsp #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       core_req_i,
  input  logic [ADDR_W-1:0]          core_addr_i,
  output logic                       core_gnt_o,
  output logic                       core_rvalid_o,
  output logic [DATA_W-1:0]          core_rdata_o,
  output logic                       core_err_o,
  input  logic                       core_rready_i,
  output logic                       cache_req_o,
  output logic [ADDR_W-1:0]          cache_addr_o,
  input  logic                       cache_gnt_i,
  input  logic                       cache_rvalid_i,
  input  logic [DATA_W-1:0]          cache_rdata_i,
  input  logic                       cache_err_i,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                       spurious_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0] out_q, out_d, cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_W:0]  mem_q [DEPTH];
  logic [DATA_W:0]  head;
  logic credit_ok, issue, has_out, rsp_in, out_dec, push, pop, empty, full;

  // Every granted request reserves a FIFO slot, so a response can never find the FIFO full.
  assign credit_ok = ({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_EXT;

  assign cache_req_o  = core_req_i & credit_ok;
  assign cache_addr_o = core_addr_i;
  assign core_gnt_o   = cache_gnt_i & credit_ok;
  assign issue        = cache_req_o & cache_gnt_i;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_CNT);
  assign has_out = (out_q != '0);

`ifdef CACHE2INSTR_SPURIOUS_CHK_EN
  logic spurious_q;
  assign rsp_in     = cache_rvalid_i & has_out;
  assign spurious_o = spurious_q;
`else
  assign rsp_in     = cache_rvalid_i & (has_out | ~full);
  assign spurious_o = 1'b0;
`endif

  assign out_dec = rsp_in & has_out;

  // Empty FIFO falls through: the live I$ word is presented directly.
  assign head          = empty ? {cache_err_i, cache_rdata_i} : mem_q[rptr_q];
  assign core_rvalid_o = ~empty | rsp_in;
  assign core_rdata_o  = core_rvalid_o ? head[DATA_W-1:0] : '0;
  assign core_err_o    = core_rvalid_o & head[DATA_W];

  assign push = rsp_in & ~(empty & core_rready_i);
  assign pop  = ~empty & core_rready_i;

  always_comb begin
    out_d  = out_q;
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    case ({issue, out_dec})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
    if (pop)  rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q      <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
`ifdef CACHE2INSTR_SPURIOUS_CHK_EN
      spurious_q <= 1'b0;
`endif
    end else begin
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
`ifdef CACHE2INSTR_SPURIOUS_CHK_EN
      spurious_q <= spurious_q | (cache_rvalid_i & ~has_out);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {cache_err_i, cache_rdata_i};
  end

  assign outstanding_o = out_q;

endmodule
